// File: rtl/rx_packet_dispatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// rx_packet_dispatch_ctrl_if
// Bundles every signal between the RX packet dispatch controller and its
// surroundings (packet decoder, RX FIFO, frame memory, config bus, status).
//
// Handshakes carried here:
//   - i_packet_done / i_packet_command: 1-cycle pulse from the decoder.
//   - o_fifo_rd / i_fifo_word: read command, data valid exactly one cycle later.
//   - o_mem_wr_en / i_mem_ready: valid/ready. A write transfers on a rising
//     clock edge where both are high. While valid is high and ready is low,
//     address and data are held stable.
//   - o_cfg_wr: 1-cycle strobe, no back-pressure.
//
// Modports:
//   master - the dispatch controller
//   slave  - the environment (FIFO, memory, config registers, host)
// ---------------------------------------------------------------------------
interface rx_packet_dispatch_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              i_packet_done;
    logic [1:0]        i_packet_command;
    logic              i_fifo_empty;
    logic [31:0]       i_fifo_word;
    logic              o_fifo_rd;
    logic              o_mem_wr_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_data;
    logic              i_mem_ready;
    logic              o_cfg_wr;
    logic [7:0]        o_cfg_addr;
    logic [23:0]       o_cfg_data;
    logic              o_busy;
    logic              o_done;
    logic              o_overrun_err;
    logic [CNT_W-1:0]  o_words_written;

    modport master (
        input  i_packet_done, i_packet_command, i_fifo_empty, i_fifo_word, i_mem_ready,
        output o_fifo_rd, o_mem_wr_en, o_mem_addr, o_mem_data, o_cfg_wr, o_cfg_addr,
               o_cfg_data, o_busy, o_done, o_overrun_err, o_words_written
    );

    modport slave (
        output i_packet_done, i_packet_command, i_fifo_empty, i_fifo_word, i_mem_ready,
        input  o_fifo_rd, o_mem_wr_en, o_mem_addr, o_mem_data, o_cfg_wr, o_cfg_addr,
               o_cfg_data, o_busy, o_done, o_overrun_err, o_words_written
    );
endinterface

// File: rtl/rx_packet_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// rx_packet_dispatch_ctrl
// Drains the UART RX FIFO after a packet has been decoded and routes each
// 32-bit word by the packet command:
//   2'b01 frame memory write (valid/ready), address from the write pointer
//   2'b10 config register write: addr = word[31:24], data = word[23:0]
//   2'b11 write pointer load from word[ADDR_W-1:0]
//   2'b00 flush (word discarded)
//
// Ports:
//   i_clock    system clock
//   i_reset_n  asynchronous reset, active low
//   bus        rx_packet_dispatch_ctrl_if.master (all data/handshake signals)
//   o_state    current FSM state for observation
// ---------------------------------------------------------------------------
module rx_packet_dispatch_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 65536,
    parameter int CNT_W     = 16
) (
    input  logic                            i_clock,
    input  logic                            i_reset_n,
    rx_packet_dispatch_ctrl_if.master       bus,
    output logic [2:0]                      o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_FLUSH = 2'b00;
    localparam logic [1:0] CMD_MEM   = 2'b01;
    localparam logic [1:0] CMD_CFG   = 2'b10;
    localparam logic [1:0] CMD_WPTR  = 2'b11;

    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(MEM_DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        cmd;
    logic [31:0]       word;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [7:0]        cfg_addr;
    logic [23:0]       cfg_data;
    logic              overrun;
    logic [CNT_W-1:0]  words_written;

    logic              fifo_rd;
    logic              mem_wr_en;
    logic              cfg_wr;
    logic              busy;
    logic              done;
    logic              mem_accept;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and strobes. All strobes are decoded from the state
    // register so the async reset clears them immediately.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        mem_wr_en  = 1'b0;
        cfg_wr     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.i_packet_done) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.i_fifo_empty) begin
                    state_next = S_DONE;
                end else begin
                    fifo_rd    = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                case (cmd)
                    CMD_MEM: begin
                        mem_wr_en = 1'b1;
                        if (bus.i_mem_ready) begin
                            state_next = S_CHECK;
                        end
                    end
                    CMD_CFG: begin
                        cfg_wr     = 1'b1;
                        state_next = S_CHECK;
                    end
                    default: begin
                        state_next = S_CHECK;
                    end
                endcase
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mem_accept = mem_wr_en && bus.i_mem_ready;

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cmd           <= CMD_FLUSH;
            word          <= '0;
            wptr          <= '0;
            mem_addr      <= '0;
            mem_data      <= '0;
            cfg_addr      <= '0;
            cfg_data      <= '0;
            overrun       <= 1'b0;
            words_written <= '0;
        end else begin
            // Command is only taken from IDLE; a pulse while busy is dropped.
            if (state == S_IDLE && bus.i_packet_done) begin
                cmd <= bus.i_packet_command;
            end

            if (state != S_IDLE && bus.i_packet_done) begin
                overrun <= 1'b1;
            end

            // The FIFO word is valid during WAIT. The sink-facing registers
            // are loaded here so they stay frozen through a memory stall and
            // keep their last value while the other sinks are in use.
            if (state == S_WAIT) begin
                word <= bus.i_fifo_word;
                if (cmd == CMD_MEM) begin
                    mem_addr <= wptr;
                    mem_data <= bus.i_fifo_word;
                end
                if (cmd == CMD_CFG) begin
                    cfg_addr <= bus.i_fifo_word[31:24];
                    cfg_data <= bus.i_fifo_word[23:0];
                end
            end

            if (mem_accept) begin
                if (wptr == WPTR_LAST) begin
                    wptr <= '0;
                end else begin
                    wptr <= wptr + 1'b1;
                end
                if (!(&words_written)) begin
                    words_written <= words_written + 1'b1;
                end
            end

            if (state == S_EXEC && cmd == CMD_WPTR) begin
                wptr <= word[ADDR_W-1:0];
            end
        end
    end

    assign bus.o_fifo_rd       = fifo_rd;
    assign bus.o_mem_wr_en     = mem_wr_en;
    assign bus.o_mem_addr      = mem_addr;
    assign bus.o_mem_data      = mem_data;
    assign bus.o_cfg_wr        = cfg_wr;
    assign bus.o_cfg_addr      = cfg_addr;
    assign bus.o_cfg_data      = cfg_data;
    assign bus.o_busy          = busy;
    assign bus.o_done          = done;
    assign bus.o_overrun_err   = overrun;
    assign bus.o_words_written = words_written;
    assign o_state             = state;

endmodule

// File: tb/tb_rx_packet_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_packet_dispatch_ctrl
// Small-geometry instance (ADDR_W=4, MEM_DEPTH=16, CNT_W=4) so pointer wrap
// and counter saturation are reached quickly. A queue-based FIFO model feeds
// the DUT; a packet-level reference model predicts memory writes, config
// writes, pointer and counter values.
// ---------------------------------------------------------------------------
module tb_rx_packet_dispatch_ctrl;

    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 16;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    rx_packet_dispatch_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    rx_packet_dispatch_ctrl #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus),
        .o_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]         fifo_q[$];
    logic [31:0]         pkt_words[$];
    logic [ADDR_W+31:0]  exp_q[$];      // expected memory writes {addr, data}
    logic [31:0]         exp_cfg_q[$];  // expected config words

    int wptr_m = 0;
    int cnt_m  = 0;
    bit ovr_m  = 1'b0;

    int reads     = 0;
    int accepts   = 0;
    int done_cnt  = 0;
    int stall_obs = 0;
    bit rd_seen   = 1'b0;

    bit stalled_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;

    // ready shaping controlled by the stimulus process
    bit rand_ready     = 1'b0;
    bit ready_hold_low = 1'b0;
    int stall_at       = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- environment drivers ----------------
    // FIFO model: a read seen before an edge pops one word, valid next cycle.
    // Memory ready: random, directed 3-cycle stall, or held low.
    bit stall_taken = 1'b0;
    int stall_left  = 0;
    always @(posedge clk) begin
        #1;
        if (rd_seen && fifo_q.size() > 0) bus.i_fifo_word = fifo_q.pop_front();
        bus.i_fifo_empty = (fifo_q.size() == 0);
        if (ready_hold_low) begin
            bus.i_mem_ready = 1'b0;
        end else if (stall_left > 0) begin
            bus.i_mem_ready = 1'b0;
            stall_left--;
        end else if (!stall_taken && stall_at >= 0 && accepts == stall_at && bus.o_mem_wr_en) begin
            stall_taken     = 1'b1;
            stall_left      = 2;
            bus.i_mem_ready = 1'b0;
        end else begin
            bus.i_mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_seen      = 1'b0;
            stalled_prev = 1'b0;
        end else begin
            rd_seen = bus.o_fifo_rd;
            if (bus.o_fifo_rd) begin
                reads++;
                chk("rd_while_empty", 64'(bus.i_fifo_empty), 64'(0));
            end
            if (bus.o_mem_wr_en) begin
                if (stalled_prev) begin
                    chk("stall_addr_stable", 64'(bus.o_mem_addr), 64'(prev_addr));
                    chk("stall_data_stable", 64'(bus.o_mem_data), 64'(prev_data));
                end
                if (bus.i_mem_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("mem_unexpected_write", 64'(1), 64'(0));
                    end else begin
                        logic [ADDR_W+31:0] e;
                        e = exp_q.pop_front();
                        chk("mem_addr", 64'(bus.o_mem_addr), 64'(e[ADDR_W+31:32]));
                        chk("mem_data", 64'(bus.o_mem_data), 64'(e[31:0]));
                    end
                    accepts++;
                    stalled_prev = 1'b0;
                end else begin
                    stall_obs++;
                    stalled_prev = 1'b1;
                    prev_addr    = bus.o_mem_addr;
                    prev_data    = bus.o_mem_data;
                end
            end else begin
                stalled_prev = 1'b0;
            end
            if (bus.o_cfg_wr) begin
                if (exp_cfg_q.size() == 0) begin
                    chk("cfg_unexpected_write", 64'(1), 64'(0));
                end else begin
                    logic [31:0] c;
                    c = exp_cfg_q.pop_front();
                    chk("cfg_addr", 64'(bus.o_cfg_addr), 64'(c[31:24]));
                    chk("cfg_data", 64'(bus.o_cfg_data), 64'(c[23:0]));
                end
            end
            if (bus.o_done) done_cnt++;
        end
    end

    // ---------------- reference model: one packet ----------------
    task automatic model_packet(input logic [1:0] cmd);
        foreach (pkt_words[i]) begin
            case (cmd)
                2'b01: begin
                    exp_q.push_back({4'(wptr_m), pkt_words[i]});
                    wptr_m = (wptr_m + 1) % MEM_DEPTH;
                    if (cnt_m < CNT_MAX) cnt_m++;
                end
                2'b10: exp_cfg_q.push_back(pkt_words[i]);
                2'b11: wptr_m = int'(pkt_words[i]) % MEM_DEPTH;
                default: ;
            endcase
        end
    endtask

    task automatic pulse(input logic [1:0] cmd);
        @(posedge clk); #1;
        bus.i_packet_done    = 1'b1;
        bus.i_packet_command = cmd;
        @(posedge clk); #1;
        bus.i_packet_done    = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done_timeout"}, 64'(k < 400), 64'(1));
    endtask

    // Loads pkt_words into the FIFO, launches the packet, optionally fires a
    // second pulse ovr_at cycles into the drain, and checks the aftermath.
    task automatic run_packet(input logic [1:0] cmd, input int ovr_at, input string tag);
        int r0, d0, n;
        n  = pkt_words.size();
        r0 = reads;
        d0 = done_cnt;
        model_packet(cmd);
        @(posedge clk); #1;
        foreach (pkt_words[i]) fifo_q.push_back(pkt_words[i]);
        pulse(cmd);
        if (ovr_at > 0) begin
            repeat (ovr_at - 1) @(posedge clk);
            chk({tag, "_busy_before_ovr"}, 64'(bus.o_busy), 64'(1));
            pulse(~cmd);
            ovr_m = 1'b1;
        end
        wait_done(d0, tag);
        repeat (3) @(negedge clk);
        chk({tag, "_reads"},     64'(reads - r0),      64'(n));
        chk({tag, "_done_once"}, 64'(done_cnt - d0),   64'(1));
        chk({tag, "_mem_left"},  64'(exp_q.size()),    64'(0));
        chk({tag, "_cfg_left"},  64'(exp_cfg_q.size()), 64'(0));
        chk({tag, "_words"},     64'(bus.o_words_written), 64'(cnt_m));
        chk({tag, "_busy"},      64'(bus.o_busy),      64'(0));
        chk({tag, "_overrun"},   64'(bus.o_overrun_err), 64'(ovr_m));
        exp_q.delete();
        exp_cfg_q.delete();
        pkt_words.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fifo_rd"}, 64'(bus.o_fifo_rd),       64'(0));
        chk({tag, "_wr_en"},   64'(bus.o_mem_wr_en),     64'(0));
        chk({tag, "_addr"},    64'(bus.o_mem_addr),      64'(0));
        chk({tag, "_data"},    64'(bus.o_mem_data),      64'(0));
        chk({tag, "_cfg_wr"},  64'(bus.o_cfg_wr),        64'(0));
        chk({tag, "_cfg_a"},   64'(bus.o_cfg_addr),      64'(0));
        chk({tag, "_cfg_d"},   64'(bus.o_cfg_data),      64'(0));
        chk({tag, "_busy"},    64'(bus.o_busy),          64'(0));
        chk({tag, "_done"},    64'(bus.o_done),          64'(0));
        chk({tag, "_ovr"},     64'(bus.o_overrun_err),   64'(0));
        chk({tag, "_words"},   64'(bus.o_words_written), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0, d0, k;
        bus.i_packet_done    = 1'b0;
        bus.i_packet_command = 2'b00;
        bus.i_fifo_empty     = 1'b1;
        bus.i_fifo_word      = '0;
        bus.i_mem_ready      = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Config packet
        pkt_words.push_back(32'h05ABCDEF);
        pkt_words.push_back(32'h07000001);
        run_packet(2'b10, 0, "t1_cfg");

        // Memory burst, 3-cycle stall on the second word
        stall_at  = 1;
        stall_obs = 0;
        for (int i = 0; i < 4; i++) pkt_words.push_back($urandom());
        run_packet(2'b01, 0, "t2_mem");
        chk("t2_stall_cycles", 64'(stall_obs), 64'(3));
        stall_at = -1;

        // Pointer load then wrap
        pkt_words.push_back(32'h0000000E);
        run_packet(2'b11, 0, "t3_ptr");
        for (int i = 0; i < 3; i++) pkt_words.push_back($urandom());
        run_packet(2'b01, 0, "t3_wrap");

        // Empty FIFO: done exactly 2 cycles after the pulse, no read
        r0 = reads;
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.i_packet_done    = 1'b1;
        bus.i_packet_command = 2'b01;
        @(posedge clk); #1;
        bus.i_packet_done    = 1'b0;
        @(negedge clk);
        chk("t4_empty_done_early", 64'(bus.o_done), 64'(0));
        chk("t4_empty_busy",       64'(bus.o_busy), 64'(1));
        @(negedge clk);
        chk("t4_empty_done_at2",   64'(bus.o_done), 64'(1));
        @(negedge clk);
        chk("t4_empty_reads",      64'(reads - r0),    64'(0));
        chk("t4_empty_done_once",  64'(done_cnt - d0), 64'(1));
        chk("t4_empty_busy_after", 64'(bus.o_busy),    64'(0));

        // Flush
        for (int i = 0; i < 5; i++) pkt_words.push_back($urandom());
        run_packet(2'b00, 0, "t4_flush");

        // Random packets with random memory back-pressure
        rand_ready = 1'b1;
        for (int p = 0; p < 16; p++) begin
            int nw;
            nw = $urandom_range(0, 5);
            for (int i = 0; i < nw; i++) pkt_words.push_back($urandom());
            run_packet(2'($urandom_range(0, 3)), 0, "rnd");
        end

        // Long burst drives the counter into saturation
        for (int i = 0; i < 12; i++) pkt_words.push_back($urandom());
        run_packet(2'b01, 0, "sat");
        chk("sat_words_max", 64'(bus.o_words_written), 64'(CNT_MAX));

        // Overrun: second pulse mid-drain must be ignored
        for (int i = 0; i < 6; i++) pkt_words.push_back($urandom());
        run_packet(2'b01, 5, "t5_ovr");
        pkt_words.push_back(32'h0000_0003);
        run_packet(2'b11, 0, "t5_sticky");
        rand_ready = 1'b0;

        // Async reset while a write is stalled
        ready_hold_low = 1'b1;
        pkt_words.push_back($urandom());
        pkt_words.push_back($urandom());
        model_packet(2'b01);
        @(posedge clk); #1;
        foreach (pkt_words[i]) fifo_q.push_back(pkt_words[i]);
        pulse(2'b01);
        k = 0;
        while (!bus.o_mem_wr_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t6_wr_en_seen", 64'(bus.o_mem_wr_en), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        fifo_q.delete();
        exp_q.delete();
        pkt_words.delete();
        wptr_m = 0;
        cnt_m  = 0;
        ovr_m  = 1'b0;
        repeat (2) @(negedge clk);
        ready_hold_low = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy_after",  64'(bus.o_busy),          64'(0));
        chk("t6_words_after", 64'(bus.o_words_written), 64'(0));

        // Pointer restarts at 0 after reset
        pkt_words.push_back($urandom());
        pkt_words.push_back($urandom());
        run_packet(2'b01, 0, "t6_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
